// File: rtl/primitive_group_scheduler.sv
// Primitive group scheduler: queues leaf primitive ranges from BVH
// traversal and issues them to the primitive tester as fixed-size batches.
module primitive_group_scheduler #(
   parameter int INDEX_WIDTH = 16,
   parameter int COUNT_WIDTH = 8,
   parameter int NUM_LEAVES  = 2,
   parameter int FIFO_DEPTH  = 16,
   parameter int UNIT_SIZE   = 4
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              start,
   input  logic                              extra_enable,
   input  logic [INDEX_WIDTH-1:0]            extra_start,
   input  logic [COUNT_WIDTH-1:0]            extra_count,
   input  logic                              leaf_valid,
   input  logic [NUM_LEAVES*INDEX_WIDTH-1:0] leaf_start,
   input  logic [NUM_LEAVES*COUNT_WIDTH-1:0] leaf_count,
   input  logic                              bvh_finished,
   input  logic                              batch_ready,
   output logic                              batch_valid,
   output logic [INDEX_WIDTH-1:0]            batch_start,
   output logic [INDEX_WIDTH-1:0]            batch_end,
   output logic [UNIT_SIZE-1:0]              batch_mask,
   output logic                              done,
   output logic                              busy,
   output logic                              overflow,
   output logic [$clog2(FIFO_DEPTH):0]       fifo_level
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;

   typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DONE} state_t;

   state_t state, state_nx;

   logic [INDEX_WIDTH-1:0] q_start [FIFO_DEPTH];
   logic [COUNT_WIDTH-1:0] q_count [FIFO_DEPTH];
   logic [PW-1:0]          rptr, wptr;
   logic [LW-1:0]          level;
   logic [INDEX_WIDTH-1:0] cur, end_q;
   logic [COUNT_WIDTH-1:0] rem;

   logic                  seed, leaf_en, pop, last, drop;
   logic [LW-1:0]         free, n_push;
   logic [NUM_LEAVES-1:0] lane_we;
   logic [PW-1:0]         lane_addr [NUM_LEAVES];

   assign seed    = (state == IDLE) && start && extra_enable &&
                    (extra_count != '0);
   assign leaf_en = leaf_valid && ((state == FETCH) || (state == ISSUE));
   assign pop     = (state == FETCH) && (level != '0);
   // remaining count, not cur vs end, so index wrap cannot confuse it
   assign last    = 32'(rem) <= 32'(UNIT_SIZE);

   always_comb begin
      free    = LW'(FIFO_DEPTH) - level;
      n_push  = '0;
      drop    = 1'b0;
      lane_we = '0;
      for (int l = 0; l < NUM_LEAVES; l++) begin
         lane_addr[l] = wptr + n_push[PW-1:0];
         if (leaf_en &&
             (leaf_count[l*COUNT_WIDTH +: COUNT_WIDTH] != '0)) begin
            if (n_push < free) begin
               lane_we[l] = 1'b1;
               n_push     = n_push + LW'(1);
            end else begin
               drop = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (seed) begin
         q_start[0] <= extra_start;
         q_count[0] <= extra_count;
      end
      for (int l = 0; l < NUM_LEAVES; l++) begin
         if (lane_we[l]) begin
            q_start[lane_addr[l]] <= leaf_start[l*INDEX_WIDTH +: INDEX_WIDTH];
            q_count[lane_addr[l]] <= leaf_count[l*COUNT_WIDTH +: COUNT_WIDTH];
         end
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:  if (start) state_nx = FETCH;
         FETCH: begin
            if (level != '0)       state_nx = ISSUE;
            else if (bvh_finished) state_nx = DONE;
         end
         ISSUE: if (batch_ready && last) state_nx = FETCH;
         DONE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         rptr     <= '0;
         wptr     <= '0;
         level    <= '0;
         overflow <= 1'b0;
         cur      <= '0;
         end_q    <= '0;
         rem      <= '0;
      end else begin
         state <= state_nx;
         if ((state == IDLE) && start) begin
            rptr     <= '0;
            wptr     <= PW'(seed);
            level    <= LW'(seed);
            overflow <= 1'b0;
         end else begin
            if (pop) rptr <= rptr + PW'(1);
            wptr  <= wptr + n_push[PW-1:0];
            level <= level + n_push - LW'(pop);
            if (drop) overflow <= 1'b1;
         end
         if (pop) begin
            cur   <= q_start[rptr];
            end_q <= q_start[rptr] + INDEX_WIDTH'(q_count[rptr]);
            rem   <= q_count[rptr];
         end else if ((state == ISSUE) && batch_ready) begin
            cur <= cur + INDEX_WIDTH'(UNIT_SIZE);
            rem <= last ? '0 : rem - COUNT_WIDTH'(UNIT_SIZE);
         end
      end
   end

   assign batch_valid = (state == ISSUE);
   assign batch_start = cur;
   assign batch_end   = end_q;
   assign done        = (state == DONE);
   assign busy        = (state != IDLE);
   assign fifo_level  = level;

   always_comb begin
      batch_mask = '0;
      for (int i = 0; i < UNIT_SIZE; i++)
         batch_mask[i] = batch_valid && (32'(rem) > 32'(i));
   end

endmodule

// File: tb/tb_primitive_group_scheduler.sv
// Directed bench for primitive_group_scheduler (depth-16 and depth-4 copies).
module tb_primitive_group_scheduler;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        extra_enable = 1'b0;
   logic [15:0] extra_start = '0;
   logic [7:0]  extra_count = '0;
   logic        leaf_valid = 1'b0;
   logic [31:0] leaf_start = '0;
   logic [15:0] leaf_count = '0;
   logic        bvh_finished = 1'b0;
   logic        batch_ready = 1'b0;

   logic        batch_valid, done, busy, overflow;
   logic [15:0] batch_start, batch_end;
   logic [3:0]  batch_mask;
   logic [4:0]  fifo_level;

   logic        batch_valid4, done4, busy4, overflow4;
   logic [15:0] batch_start4, batch_end4;
   logic [3:0]  batch_mask4;
   logic [2:0]  fifo_level4;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   primitive_group_scheduler dut (
      .clk(clk), .reset(reset), .start(start),
      .extra_enable(extra_enable), .extra_start(extra_start),
      .extra_count(extra_count), .leaf_valid(leaf_valid),
      .leaf_start(leaf_start), .leaf_count(leaf_count),
      .bvh_finished(bvh_finished), .batch_ready(batch_ready),
      .batch_valid(batch_valid), .batch_start(batch_start),
      .batch_end(batch_end), .batch_mask(batch_mask), .done(done),
      .busy(busy), .overflow(overflow), .fifo_level(fifo_level)
   );

   primitive_group_scheduler #(.FIFO_DEPTH(4)) dut4 (
      .clk(clk), .reset(reset), .start(start),
      .extra_enable(extra_enable), .extra_start(extra_start),
      .extra_count(extra_count), .leaf_valid(leaf_valid),
      .leaf_start(leaf_start), .leaf_count(leaf_count),
      .bvh_finished(bvh_finished), .batch_ready(batch_ready),
      .batch_valid(batch_valid4), .batch_start(batch_start4),
      .batch_end(batch_end4), .batch_mask(batch_mask4), .done(done4),
      .busy(busy4), .overflow(overflow4), .fifo_level(fifo_level4)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      start = 1'b0;
      extra_enable = 1'b0;
      leaf_valid = 1'b0;
      leaf_count = '0;
      bvh_finished = 1'b0;
      batch_ready = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      tick();
      checks++;
      if (batch_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0 ||
          overflow !== 1'b0 || fifo_level !== 5'd0) begin
         failures++;
         $display("FAIL reset_ctrl: got v%b d%b b%b o%b l%0d exp 0 0 0 0 0",
                  batch_valid, done, busy, overflow, fifo_level);
      end
      checks++;
      if (batch_start !== 16'd0 || batch_end !== 16'd0 ||
          batch_mask !== 4'd0) begin
         failures++;
         $display("FAIL reset_data: got %0d %0d %b exp 0 0 0000",
                  batch_start, batch_end, batch_mask);
      end
      reset = 1'b0;
   endtask

   task automatic test_single();
      start = 1'b1; extra_enable = 1'b1;
      extra_start = 16'd1000; extra_count = 8'd3;
      bvh_finished = 1'b1; batch_ready = 1'b1;
      tick();
      start = 1'b0; extra_enable = 1'b0;
      checks++;
      if (busy !== 1'b1 || batch_valid !== 1'b0 || fifo_level !== 5'd1) begin
         failures++;
         $display("FAIL single_fetch: got b%b v%b l%0d exp b1 v0 l1",
                  busy, batch_valid, fifo_level);
      end
      tick();
      checks++;
      if (batch_valid !== 1'b1 || batch_start !== 16'd1000) begin
         failures++;
         $display("FAIL single_batch: got v%b s%0d exp v1 s1000",
                  batch_valid, batch_start);
      end
      checks++;
      if (batch_end !== 16'd1003 || batch_mask !== 4'b0111) begin
         failures++;
         $display("FAIL single_mask: got e%0d m%b exp e1003 m0111",
                  batch_end, batch_mask);
      end
      tick();
      checks++;
      if (batch_valid !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL single_n3: got v%b d%b exp v0 d0", batch_valid, done);
      end
      tick();
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("FAIL single_done: got %b exp 1", done);
      end
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL single_idle: got d%b b%b exp d0 b0", done, busy);
      end
   endtask

   task automatic test_leaf_lanes();
      bvh_finished = 1'b0; batch_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      leaf_valid = 1'b1;
      leaf_start = {16'd0, 16'd20};
      leaf_count = {8'd0, 8'd9};
      tick();
      leaf_valid = 1'b0; leaf_count = '0;
      checks++;
      if (fifo_level !== 5'd1 || batch_valid !== 1'b0) begin
         failures++;
         $display("FAIL leaf_queued: got l%0d v%b exp l1 v0",
                  fifo_level, batch_valid);
      end
      bvh_finished = 1'b1;
      tick();
      checks++;
      if (batch_valid !== 1'b1 || batch_start !== 16'd20 ||
          batch_mask !== 4'b1111 || batch_end !== 16'd29) begin
         failures++;
         $display("FAIL leaf_b0: got v%b s%0d m%b e%0d exp v1 s20 m1111 e29",
                  batch_valid, batch_start, batch_mask, batch_end);
      end
      tick();
      checks++;
      if (batch_valid !== 1'b1 || batch_start !== 16'd24 ||
          batch_mask !== 4'b1111) begin
         failures++;
         $display("FAIL leaf_b1: got v%b s%0d m%b exp v1 s24 m1111",
                  batch_valid, batch_start, batch_mask);
      end
      tick();
      checks++;
      if (batch_valid !== 1'b1 || batch_start !== 16'd28 ||
          batch_mask !== 4'b0001 || batch_end !== 16'd29) begin
         failures++;
         $display("FAIL leaf_b2: got v%b s%0d m%b e%0d exp v1 s28 m0001 e29",
                  batch_valid, batch_start, batch_mask, batch_end);
      end
      tick();
      checks++;
      if (batch_valid !== 1'b0 || fifo_level !== 5'd0) begin
         failures++;
         $display("FAIL leaf_fetch: got v%b l%0d exp v0 l0",
                  batch_valid, fifo_level);
      end
      tick();
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("FAIL leaf_done: got %b exp 1", done);
      end
      tick();
   endtask

   task automatic test_stall();
      start = 1'b1; extra_enable = 1'b1;
      extra_start = 16'd100; extra_count = 8'd6;
      bvh_finished = 1'b1; batch_ready = 1'b0;
      tick();
      extra_enable = 1'b0;
      tick();
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (batch_valid !== 1'b1 || batch_start !== 16'd100 ||
             batch_end !== 16'd106 || batch_mask !== 4'b1111) begin
            failures++;
            $display("FAIL stall_hold%0d: got v%b s%0d e%0d m%b exp v1 s100 e106 m1111",
                     i, batch_valid, batch_start, batch_end, batch_mask);
         end
         if (i < 5) tick();
      end
      start = 1'b0;
      batch_ready = 1'b1;
      tick();
      checks++;
      if (batch_valid !== 1'b1 || batch_start !== 16'd104 ||
          batch_mask !== 4'b0011) begin
         failures++;
         $display("FAIL stall_b1: got v%b s%0d m%b exp v1 s104 m0011",
                  batch_valid, batch_start, batch_mask);
      end
      tick();
      tick();
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("FAIL stall_done: got %b exp 1", done);
      end
      tick();
   endtask

   task automatic test_idle_ignore();
      leaf_valid = 1'b1;
      leaf_start = {16'd7, 16'd5};
      leaf_count = {8'd2, 8'd2};
      bvh_finished = 1'b1;
      tick();
      leaf_valid = 1'b0; leaf_count = '0;
      checks++;
      if (fifo_level !== 5'd0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL idle_leaf: got l%0d b%b exp l0 b0", fifo_level, busy);
      end
   endtask

   task automatic test_overflow();
      logic [15:0] exp4 [5] = '{16'd200, 16'd201, 16'd202, 16'd203, 16'd204};
      int  nb;
      logic got_done;
      bvh_finished = 1'b0; batch_ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      leaf_valid = 1'b1;
      leaf_start = {16'd201, 16'd200}; leaf_count = {8'd1, 8'd1};
      tick();
      checks++;
      if (fifo_level4 !== 3'd2) begin
         failures++;
         $display("FAIL ovf_l2: got %0d exp 2", fifo_level4);
      end
      leaf_start = {16'd0, 16'd202}; leaf_count = {8'd0, 8'd1};
      tick();
      checks++;
      if (batch_valid4 !== 1'b1 || batch_start4 !== 16'd200 ||
          fifo_level4 !== 3'd2) begin
         failures++;
         $display("FAIL ovf_pushpop: got v%b s%0d l%0d exp v1 s200 l2",
                  batch_valid4, batch_start4, fifo_level4);
      end
      leaf_start = {16'd0, 16'd203}; leaf_count = {8'd0, 8'd1};
      tick();
      checks++;
      if (fifo_level4 !== 3'd3 || overflow4 !== 1'b0) begin
         failures++;
         $display("FAIL ovf_l3: got l%0d o%b exp l3 o0", fifo_level4, overflow4);
      end
      leaf_start = {16'd205, 16'd204}; leaf_count = {8'd1, 8'd1};
      tick();
      leaf_valid = 1'b0; leaf_count = '0;
      checks++;
      if (fifo_level4 !== 3'd4 || overflow4 !== 1'b1) begin
         failures++;
         $display("FAIL ovf_drop: got l%0d o%b exp l4 o1", fifo_level4, overflow4);
      end
      checks++;
      if (overflow !== 1'b0) begin
         failures++;
         $display("FAIL ovf_deep: got %b exp 0", overflow);
      end
      batch_ready = 1'b1; bvh_finished = 1'b1;
      nb = 0; got_done = 1'b0;
      for (int i = 0; i < 40 && !got_done; i++) begin
         if (batch_valid4) begin
            checks++;
            if (nb >= 5) begin
               failures++;
               $display("FAIL ovf_extra: got s%0d exp none", batch_start4);
            end else if (batch_start4 !== exp4[nb]) begin
               failures++;
               $display("FAIL ovf_order%0d: got %0d exp %0d",
                        nb, batch_start4, exp4[nb]);
            end
            nb++;
         end
         if (done4) got_done = 1'b1;
         else tick();
      end
      checks++;
      if (!got_done || nb != 5 || overflow4 !== 1'b1) begin
         failures++;
         $display("FAIL ovf_drain: got done%b n%0d o%b exp done1 n5 o1",
                  got_done, nb, overflow4);
      end
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (overflow4 !== 1'b0 || busy4 !== 1'b1) begin
         failures++;
         $display("FAIL ovf_clear: got o%b b%b exp o0 b1", overflow4, busy4);
      end
   endtask

   task automatic test_wrap();
      int   p, nb;
      logic got_done;
      logic [15:0] es;
      bvh_finished = 1'b0; batch_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      p = 0; nb = 0; got_done = 1'b0;
      for (int c = 0; c < 400 && !got_done; c++) begin
         if (batch_valid) begin
            es = 16'(500 + nb);
            checks++;
            if (batch_start !== es || batch_mask !== 4'b0001 ||
                batch_end !== es + 16'd1) begin
               failures++;
               $display("FAIL wrap_b%0d: got s%0d m%b e%0d exp s%0d m0001",
                        nb, batch_start, batch_mask, batch_end, es);
            end
            nb++;
         end
         if (done) got_done = 1'b1;
         if (c % 4 == 0 && p < 40) begin
            leaf_valid = 1'b1;
            leaf_start = {16'(501 + p), 16'(500 + p)};
            leaf_count = {8'd1, 8'd1};
            p += 2;
         end else begin
            leaf_valid = 1'b0;
            leaf_count = '0;
         end
         bvh_finished = (p >= 40) && !leaf_valid;
         if (!got_done) tick();
      end
      checks++;
      if (!got_done || nb != 40 || overflow !== 1'b0) begin
         failures++;
         $display("FAIL wrap_total: got done%b n%0d o%b exp done1 n40 o0",
                  got_done, nb, overflow);
      end
      leaf_valid = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      logic saw_done;
      start = 1'b1; extra_enable = 1'b1;
      extra_start = 16'd1000; extra_count = 8'd12;
      bvh_finished = 1'b1; batch_ready = 1'b1;
      tick();
      start = 1'b0; extra_enable = 1'b0;
      tick();
      checks++;
      if (batch_valid !== 1'b1) begin
         failures++;
         $display("FAIL mid_issue: got %b exp 1", batch_valid);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (batch_valid !== 1'b0 || busy !== 1'b0 || fifo_level !== 5'd0 ||
          batch_start !== 16'd0) begin
         failures++;
         $display("FAIL mid_async: got v%b b%b l%0d s%0d exp 0 0 0 0",
                  batch_valid, busy, fifo_level, batch_start);
      end
      tick();
      reset = 1'b0;
      saw_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (done || busy) saw_done = 1'b1;
      end
      checks++;
      if (saw_done) begin
         failures++;
         $display("FAIL mid_quiet: got activity 1 exp 0");
      end
      test_single();
   endtask

   initial begin
      test_reset();
      test_single();
      do_reset();
      test_leaf_lanes();
      do_reset();
      test_stall();
      do_reset();
      test_idle_ignore();
      do_reset();
      test_overflow();
      do_reset();
      test_wrap();
      do_reset();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/primitive_group_scheduler.md
PRIMITIVE_GROUP_SCHEDULER -- requirements
Module: primitive_group_scheduler

Interface
REQ-001 Parameter INDEX_WIDTH, 16, primitive index width.
REQ-002 Parameter COUNT_WIDTH, 8, primitives-per-group count width.
REQ-003 Parameter NUM_LEAVES, 2, leaf groups offered per cycle by BVH traversal.
REQ-004 Parameter FIFO_DEPTH, 16, group FIFO entries; power of 2, >= NUM_LEAVES+1.
REQ-005 Parameter UNIT_SIZE, 4, primitives tested per batch; power of 2, >= 1.
REQ-006 Clocking: one clock; reset is asynchronous and active-high.
REQ-007 clk  in  1  clock, all state on rising edge.
REQ-008 reset  in  1  asynchronous active-high reset.
REQ-009 start  in  1  begin new ray; honoured only in IDLE.
REQ-010 extra_enable  in  1  seed extra group (ground plane etc.) at start.
REQ-011 extra_start  in  INDEX_WIDTH  first primitive of extra group.
REQ-012 extra_count  in  COUNT_WIDTH  primitive count of extra group.
REQ-013 leaf_valid  in  1  leaf groups on leaf_* valid this cycle.
REQ-014 leaf_start  in  NUM_LEAVES*INDEX_WIDTH  per-lane first primitive, lane 0 in LSBs.
REQ-015 leaf_count  in  NUM_LEAVES*COUNT_WIDTH  per-lane count; 0 = no group.
REQ-016 bvh_finished  in  1  traversal complete, no further leaf_valid for this ray.
REQ-017 batch_ready  in  1  primitive tester accepts batch.
REQ-018 batch_valid  out  1  batch presented.
REQ-019 batch_start  out  INDEX_WIDTH  first primitive of batch.
REQ-020 batch_end  out  INDEX_WIDTH  exclusive real end of current group.
REQ-021 batch_mask  out  UNIT_SIZE  bit i set iff batch_start+i < batch_end.
REQ-022 done  out  1  one-cycle pulse: all groups issued.
REQ-023 busy  out  1  state != IDLE.
REQ-024 overflow  out  1  sticky: a group was dropped on full FIFO.
REQ-025 fifo_level  out  $clog2(FIFO_DEPTH)+1  entries occupied.

Function
REQ-026 States IDLE, FETCH, ISSUE, DONE; one-hot or binary encoding free.
REQ-027 IDLE: start=1 -> clear FIFO pointers and overflow, enqueue extra group if extra_enable and extra_count!=0, -> FETCH.
REQ-028 FETCH: FIFO non-empty -> pop head into cur/end (end = start+count, mod 2^INDEX_WIDTH), -> ISSUE; empty and bvh_finished -> DONE; else stay.
REQ-029 ISSUE: batch_valid=1, batch_start=cur; on batch_valid&&batch_ready cur += UNIT_SIZE; if new cur >= end (count-aligned up to UNIT_SIZE) -> FETCH.
REQ-030 Number of batches per group = ceil(count/UNIT_SIZE); last batch mask clears lanes beyond end.
REQ-031 batch_start/batch_end/batch_mask stable while batch_valid && !batch_ready.
REQ-032 DONE: done=1 for exactly one cycle, -> IDLE.
REQ-033 Enqueue accepted when leaf_valid=1 and state in {FETCH, ISSUE}; ignored in IDLE and DONE.
REQ-034 Zero-count lanes skipped; non-zero lanes written in ascending lane order to consecutive slots.
REQ-035 Non-zero lanes exceeding free slots dropped (higher lanes first); overflow set, cleared only by accepted start or reset.
REQ-036 Same-cycle push and pop allowed; pop uses pre-cycle contents; free slots computed before pop.
REQ-037 Read/write pointers wrap modulo FIFO_DEPTH; full = level==FIFO_DEPTH.
REQ-038 Latency: start at cycle N -> FETCH at N+1 -> batch_valid at N+2 if extra group seeded.
REQ-039 bvh_finished sampled only in FETCH with empty FIFO; earlier assertion has no effect.
REQ-040 start outside IDLE ignored; no mid-ray restart.

Reset
REQ-041 reset=1 asynchronously forces IDLE, pointers 0, fifo_level=0, batch_valid=0, done=0, busy=0, overflow=0, batch_start=0, batch_end=0, batch_mask=0.
REQ-042 reset asserted mid-ray discards all queued groups; no done pulse follows.

Verification
REQ-043 start, extra 1000/3, UNIT_SIZE=4, batch_ready=1, bvh_finished=1 -> one batch start 1000 end 1003 mask 0111 at N+2, done at N+4.
REQ-044 leaf lanes (20,9),(0,0) with ready=1 -> batches 20 mask 1111, 24 mask 1111, 28 mask 0001, end=29; lane 1 not queued.
REQ-045 batch_ready=0 for 5 cycles during ISSUE -> outputs held constant, cur unchanged, no batch lost.
REQ-046 FIFO_DEPTH=4 with 3 entries, leaf lanes both non-zero -> lane 0 stored, lane 1 dropped, overflow=1, fifo_level=4.
REQ-047 Pointer wrap: 40 single-primitive groups through FIFO_DEPTH=16 -> 40 batches in push order, no overflow.
REQ-048 reset pulse during ISSUE -> immediate IDLE, batch_valid=0, level 0; next start behaves as REQ-043.
